// File: rtl/instr_fetch_cache_pkg.sv
// Shared encodings for the instruction fetch stage: scheduler states, fetcher states
// and a saturating counter helper.
package instr_fetch_cache_pkg;

  localparam logic [3:0] CORE_FETCH  = 4'b0001;
  localparam logic [3:0] CORE_DECODE = 4'b0010;

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StFetching = 3'b001,
    StFetched  = 3'b010
  } fetch_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/icache_store.sv
// Direct-mapped instruction cache storage: valid/tag/data arrays with a combinational
// lookup port, one write port and a flash invalidate.
module icache_store #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned CACHE_LINES = 8,
  localparam int unsigned INDEX_BITS = $clog2(CACHE_LINES),
  localparam int unsigned TAG_BITS   = ADDR_BITS - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] lookup_idx,
  input  logic [TAG_BITS-1:0]   lookup_tag,
  output logic                  lookup_hit,
  output logic [DATA_BITS-1:0]  lookup_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic                  invalidate
);

  logic [CACHE_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]    tag_q  [CACHE_LINES];
  logic [DATA_BITS-1:0]   data_q [CACHE_LINES];

  // Invalidate wins over a coincident fill so the filled line stays invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (invalidate) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign lookup_hit  = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign lookup_data = data_q[lookup_idx];

endmodule

// File: rtl/instr_fetch_cache.sv
// Instruction fetch stage: looks up the PC in a direct-mapped cache on FETCH, fills from
// program memory over a valid/ready read on a miss, and hands the instruction to decode.
module instr_fetch_cache
  import instr_fetch_cache_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned CACHE_LINES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           core_state,
  input  logic [ADDR_BITS-1:0] current_pc,
  input  logic                 invalidate,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic [2:0]           fetcher_state,
  output logic [DATA_BITS-1:0] instruction,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int unsigned INDEX_BITS = $clog2(CACHE_LINES);
  localparam int unsigned TAG_BITS   = ADDR_BITS - INDEX_BITS;

  fetch_state_e state_q, state_d;

  logic                 req_valid_q, req_valid_d;
  logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
  logic [DATA_BITS-1:0] instr_q, instr_d;
  logic [15:0]          hit_q, hit_d;
  logic [15:0]          miss_q, miss_d;

  logic                 lookup_hit;
  logic [DATA_BITS-1:0] lookup_data;
  logic                 fill_we;

  logic is_fetch;
  logic is_decode;
  assign is_fetch  = (core_state == CORE_FETCH);
  assign is_decode = (core_state == CORE_DECODE);

  icache_store #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_BITS  (DATA_BITS),
    .CACHE_LINES(CACHE_LINES)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .lookup_idx (current_pc[INDEX_BITS-1:0]),
    .lookup_tag (current_pc[ADDR_BITS-1:INDEX_BITS]),
    .lookup_hit (lookup_hit),
    .lookup_data(lookup_data),
    .we         (fill_we),
    .wr_idx     (req_addr_q[INDEX_BITS-1:0]),
    .wr_tag     (req_addr_q[ADDR_BITS-1:INDEX_BITS]),
    .wr_data    (mem_read_data),
    .invalidate (invalidate)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (is_fetch) begin
          state_d = lookup_hit ? StFetched : StFetching;
        end
      end
      StFetching: begin
        if (mem_read_ready) begin
          state_d = StFetched;
        end
      end
      StFetched: begin
        if (is_decode) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next-values; every output is registered below.
  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    instr_d     = instr_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    fill_we     = 1'b0;
    case (state_q)
      StIdle: begin
        if (is_fetch) begin
          if (lookup_hit) begin
            instr_d = lookup_data;
            hit_d   = sat_inc(hit_q);
          end else begin
            req_valid_d = 1'b1;
            req_addr_d  = current_pc;
            miss_d      = sat_inc(miss_q);
          end
        end
      end
      StFetching: begin
        if (mem_read_ready) begin
          instr_d     = mem_read_data;
          req_valid_d = 1'b0;
          fill_we     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      instr_q     <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      instr_q     <= instr_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign mem_read_valid   = req_valid_q;
  assign mem_read_address = req_addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;
  assign hit_count        = hit_q;
  assign miss_count       = miss_q;

endmodule

// File: tb/tb_instr_fetch_cache.sv
// Self-checking bench for instr_fetch_cache: directed vector table, hand-written corner
// sequences and randomized fetches against a pc-keyed cache model.
module tb_instr_fetch_cache;

  localparam logic [3:0] FETCH  = 4'b0001;
  localparam logic [3:0] DECODE = 4'b0010;
  localparam logic [3:0] OTHER  = 4'b0100;
  localparam int unsigned S_IDLE     = 0;
  localparam int unsigned S_FETCHING = 1;
  localparam int unsigned S_FETCHED  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  instr_fetch_cache #(
    .ADDR_BITS  (8),
    .DATA_BITS  (16),
    .CACHE_LINES(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .core_state      (core_state),
    .current_pc      (current_pc),
    .invalidate      (invalidate),
    .mem_read_valid  (mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .fetcher_state   (fetcher_state),
    .instruction     (instruction),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Model: per line, which full pc is cached and its instruction.
  bit          m_valid [8];
  logic [7:0]  m_pc    [8];
  logic [15:0] m_data  [8];

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
    int          delay;
    int          inv_mode;  // 0 none, 1 pulse before fetch, 2 with the fill's ready
    bit          exp_hit;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  function automatic bit model_hit(input logic [7:0] pc, input int inv_mode);
    return (inv_mode != 1) && m_valid[pc[2:0]] && (m_pc[pc[2:0]] == pc);
  endfunction

  task automatic do_fetch(input logic [7:0] pc, input logic [15:0] data, input int delay,
                          input int inv_mode, input bit exp_hit, input logic [15:0] exp_instr);
    if (inv_mode == 1) begin
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      model_clear();
    end
    core_state = FETCH;
    current_pc = pc;
    @(negedge clk);
    if (exp_hit) begin
      exp_hits++;
      check("hit_state", 32'(fetcher_state), S_FETCHED);
      check("hit_no_request", 32'(mem_read_valid), 0);
    end else begin
      exp_misses++;
      check("miss_request", 32'(mem_read_valid), 1);
      check("miss_address", 32'(mem_read_address), 32'(pc));
      check("miss_state", 32'(fetcher_state), S_FETCHING);
      for (int i = 1; i < delay; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(mem_read_valid), 1);
        check("hold_address", 32'(mem_read_address), 32'(pc));
        check("hold_state", 32'(fetcher_state), S_FETCHING);
      end
      mem_read_ready = 1'b1;
      mem_read_data  = data;
      if (inv_mode == 2) invalidate = 1'b1;
      @(negedge clk);
      mem_read_ready = 1'b0;
      invalidate     = 1'b0;
      mem_read_data  = 16'($urandom);
      check("fill_state", 32'(fetcher_state), S_FETCHED);
      check("fill_request_drop", 32'(mem_read_valid), 0);
      if (inv_mode == 2) begin
        model_clear();
      end else begin
        m_valid[pc[2:0]] = 1'b1;
        m_pc[pc[2:0]]    = pc;
        m_data[pc[2:0]]  = data;
      end
    end
    check("instruction", 32'(instruction), 32'(exp_instr));
    check("hit_count", 32'(hit_count), exp_hits);
    check("miss_count", 32'(miss_count), exp_misses);
    core_state = DECODE;
    @(negedge clk);
    check("decode_to_idle", 32'(fetcher_state), S_IDLE);
    check("instruction_held", 32'(instruction), 32'(exp_instr));
    core_state = OTHER;
  endtask

  initial begin
    logic [7:0]  pc;
    logic [15:0] data;
    int          inv_mode;
    bit          hit;

    vecs[0] = '{8'h05, 16'h9105, 3,  0, 1'b0, 16'h9105};  // cold miss
    vecs[1] = '{8'h05, 16'h0000, 1,  0, 1'b1, 16'h9105};  // warm hit
    vecs[2] = '{8'h03, 16'h1303, 1,  0, 1'b0, 16'h1303};
    vecs[3] = '{8'h0B, 16'h1B0B, 2,  0, 1'b0, 16'h1B0B};  // conflict on idx 3
    vecs[4] = '{8'h03, 16'h2303, 1,  0, 1'b0, 16'h2303};  // evicted, misses again
    vecs[5] = '{8'h05, 16'h3105, 1,  1, 1'b0, 16'h3105};  // invalidate then refetch
    vecs[6] = '{8'h05, 16'h0000, 1,  0, 1'b1, 16'h3105};
    vecs[7] = '{8'h0D, 16'h4D0D, 10, 2, 1'b0, 16'h4D0D};  // long wait, invalidate at fill
    vecs[8] = '{8'h0D, 16'h5D0D, 1,  0, 1'b0, 16'h5D0D};  // line was not kept
    vecs[9] = '{8'h0D, 16'h0000, 1,  0, 1'b1, 16'h5D0D};

    reset          = 1'b1;
    core_state     = OTHER;
    current_pc     = '0;
    invalidate     = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_state", 32'(fetcher_state), S_IDLE);
    check("reset_valid", 32'(mem_read_valid), 0);
    check("reset_address", 32'(mem_read_address), 0);
    check("reset_instruction", 32'(instruction), 0);
    check("reset_hits", 32'(hit_count), 0);
    check("reset_misses", 32'(miss_count), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      do_fetch(vecs[v].pc, vecs[v].data, vecs[v].delay, vecs[v].inv_mode, vecs[v].exp_hit,
               vecs[v].exp_instr);
    end

    // Ready while idle must not disturb anything.
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hFFFF;
    @(negedge clk);
    mem_read_ready = 1'b0;
    check("idle_ready_state", 32'(fetcher_state), S_IDLE);
    check("idle_ready_valid", 32'(mem_read_valid), 0);
    check("idle_ready_instr", 32'(instruction), 32'h5D0D);

    // Reset with a request outstanding, then a late ready.
    core_state = FETCH;
    current_pc = 8'hE7;
    @(negedge clk);
    check("pre_reset_request", 32'(mem_read_valid), 1);
    reset      = 1'b1;
    core_state = OTHER;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_state", 32'(fetcher_state), S_IDLE);
    check("midreset_valid", 32'(mem_read_valid), 0);
    check("midreset_instr", 32'(instruction), 0);
    check("midreset_misses", 32'(miss_count), 0);
    exp_hits   = 0;
    exp_misses = 0;
    model_clear();
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hBEEF;
    @(negedge clk);
    mem_read_ready = 1'b0;
    check("late_ready_state", 32'(fetcher_state), S_IDLE);
    check("late_ready_instr", 32'(instruction), 0);
    do_fetch(8'hE7, 16'h0E07, 1, 0, 1'b0, 16'h0E07);

    // Randomized fetches against the model.
    for (int r = 0; r < 60; r++) begin
      pc       = 8'($urandom_range(0, 31));
      data     = 16'($urandom);
      inv_mode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      hit      = model_hit(pc, inv_mode);
      do_fetch(pc, data, int'($urandom_range(1, 4)), inv_mode, hit,
               hit ? m_data[pc[2:0]] : data);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_fetch_cache.md
# instr_fetch_cache

Per-core instruction fetch stage that sits directly upstream of the decoder. On the core's FETCH state it looks up the current PC in a small direct-mapped instruction cache. On a hit it returns the 16-bit instruction. On a miss it runs a valid/ready read against program memory and fills the cache line. It drives `instruction` into the decoder and reports `fetcher_state` to the core scheduler, which advances FETCH→DECODE on FETCHED.

## Interface
Parameters:
- ADDR_BITS, 8, program-memory address width (PC width)
- DATA_BITS, 16, instruction width
- CACHE_LINES, 8, cache entries; power of two, ≥2; INDEX_BITS = log2(CACHE_LINES), TAG_BITS = ADDR_BITS − INDEX_BITS

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- core_state  in  4  scheduler state; FETCH = 4'b0001, DECODE = 4'b0010
- current_pc  in  ADDR_BITS  PC to fetch; stable while core_state == FETCH
- invalidate  in  1  single-cycle pulse; clears all cache valid bits
- mem_read_valid  out  1  program-memory read request
- mem_read_address  out  ADDR_BITS  request address
- mem_read_ready  in  1  memory response strobe, data valid this cycle
- mem_read_data  in  DATA_BITS  response data
- fetcher_state  out  3  IDLE 3'b000, FETCHING 3'b001, FETCHED 3'b010
- instruction  out  DATA_BITS  fetched instruction, held stable in FETCHED
- hit_count  out  16  saturating cache-hit counter
- miss_count  out  16  saturating cache-miss counter

## Operation
- Reset values: all outputs are 0, fetcher_state is IDLE, and every valid bit is cleared. Tag and data arrays are don't-care.
- Address split: idx = current_pc[INDEX_BITS-1:0], tag = current_pc[ADDR_BITS-1:INDEX_BITS].
- IDLE, when core_state ≠ FETCH: stay in IDLE and hold all outputs.
- IDLE, when core_state == FETCH and the line hits (valid[idx] && tag_arr[idx] == tag):
  - instruction ← data_arr[idx]
  - state → FETCHED
  - hit_count increments
- IDLE, when core_state == FETCH and the line misses:
  - mem_read_valid ← 1, mem_read_address ← current_pc
  - state → FETCHING
  - miss_count increments
- FETCHING:
  - mem_read_valid and mem_read_address hold until mem_read_ready is sampled high.
  - On ready: instruction ← mem_read_data, mem_read_valid ← 0, line idx is written (valid=1, tag, data), state → FETCHED.
- FETCHED: hold instruction. When core_state == DECODE, state → IDLE; instruction keeps its value so the decoder samples it.
- Invalidate:
  - Clears all valid bits at the next edge in any state.
  - If it coincides with a fill, the instruction is still delivered and FETCHED is still entered, but the line is not marked valid.
  - If it coincides with a lookup in IDLE, that lookup uses the pre-clear valid bits.
- mem_read_ready outside FETCHING is ignored.
- Counters saturate at 16'hFFFF and are cleared only by reset.
- Reset mid-transaction abandons the outstanding request. mem_read_valid is 0 the cycle after the reset edge, and a late ready is ignored.

## Timing
- Hit: core_state becomes FETCH at cycle N; fetcher_state == FETCHED and instruction are valid from N+1.
- Miss: mem_read_valid is high from N+1. If ready arrives at cycle M, FETCHED and instruction are valid from M+1. With a 1-cycle memory the minimum is N+2.
- FETCHED → IDLE takes 1 cycle after core_state == DECODE is sampled.
- Only one outstanding request at a time, and no request issues outside FETCH.
- All state is registered. There are no combinational paths from input to output.

## Structure
- Shared package holds:
  - core_state encodings (FETCH, DECODE)
  - fetcher_state encodings (IDLE, FETCHING, FETCHED)
  - the fetch-state enum typedef
- Sub-module `icache_store`: tag, data and valid arrays with:
  - a combinational lookup port (idx, tag → hit, data)
  - a write port (we, idx, tag, data)
  - an invalidate-all input
- The top level holds the FSM, request registers and counters.

## Test plan
- Cold miss: reset, then pc=8'h05, FETCH with ready 3 cycles after the request, data 16'h9105 → mem_read_address=8'h05, FETCHED at M+1, instruction=16'h9105, miss_count=1.
- Warm hit: refetch pc=8'h05 → no mem_read_valid, FETCHED at N+1, instruction=16'h9105, hit_count=1.
- Conflict: fill pc=8'h03, then fetch pc=8'h0B (same idx, different tag) → miss, new fill. Refetch 8'h03 → miss again.
- Invalidate: after filling 8'h05, pulse invalidate, then fetch 8'h05 → miss. Invalidate coincident with a fill → instruction delivered, next fetch of the same PC misses.
- Handshake: hold ready low 10 cycles → mem_read_valid and address stable throughout. Ready pulse while IDLE → no state change.
- Reset mid-FETCHING → next cycle all outputs 0 and IDLE. A subsequent late ready is ignored and no line is written.
